// File: rtl/mips_mem_pkg.sv
// Shared definitions for the pipe_MIPS32 unified-memory arbiter.
//   - FSM state encodings for the access sequencer
//   - owner encoding for the access in flight
//   - default address/data widths
package mips_mem_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;

    // Sequencer states (kept as plain constants for legacy tools).
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_WAIT = 2'd1;
    localparam logic [1:0] WR_DONE = 2'd2;

    // Which requester owns the access in flight.
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

endpackage

// File: rtl/mips_starve_ctr.sv
// Saturating starvation counter for the fetch port.
//   clk, rst : clock, asynchronous active-low reset
//   inc      : count one lost arbitration (saturates at MAX_STARVE)
//   clr      : clear to zero (wins over inc)
//   at_max   : counter has reached MAX_STARVE
module mips_starve_ctr #(
    parameter int MAX_STARVE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int CNT_W = $clog2(MAX_STARVE + 1);

    logic [CNT_W-1:0] cnt;

    assign at_max = (cnt == CNT_W'(MAX_STARVE));

    // NOTE: sequential state is always written with non-blocking assignments
    // so every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Single-port memory arbiter / access sequencer for pipe_MIPS32.
// Shares one unified memory between instruction fetch (IF) and load/store (LS),
// one access at a time, with a fixed read latency.
//   clk, rst              : clock, asynchronous active-low reset
//   if_req/if_addr        : fetch request (held until if_gnt)
//   if_gnt/if_valid       : grant pulse / fetch data valid pulse
//   if_rdata              : fetch data, meaningful with if_valid
//   if_flush              : branch taken, discard the outstanding fetch reply
//   ls_req/ls_we/ls_addr/ls_wdata : load/store request (held until ls_gnt)
//   ls_gnt/ls_valid       : grant pulse / load data or store-complete pulse
//   ls_rdata              : load data, meaningful with ls_valid
//   halt                  : block new grants
//   mem_en/mem_we/mem_addr/mem_wdata : registered memory strobe and command
//   mem_rdata             : memory read data, valid RD_LAT cycles after mem_en
module mips_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RD_LAT     = 2,
    parameter int MAX_STARVE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              if_flush,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_valid,
    output logic [DATA_W-1:0] ls_rdata,
    input  logic              halt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int LAT_W = 3;

    logic [1:0]       state;
    logic             owner;
    logic [LAT_W-1:0] lat_cnt;
    logic             drop;        // outstanding fetch reply is to be discarded
    logic             if_valid_q;

    logic decide;
    logic if_win;
    logic ls_win;
    logic starve_inc;
    logic starve_clr;
    logic starve_at_max;
    logic if_outstanding;

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        decide         = 1'b0;
        if_win         = 1'b0;
        ls_win         = 1'b0;
        starve_inc     = 1'b0;
        starve_clr     = 1'b0;
        if_outstanding = (state == RD_WAIT) && (owner == OWN_IF);
        if (state == IDLE) begin
            decide = !halt && (if_req || ls_req);
            // LS has priority unless IF has lost MAX_STARVE times in a row.
            if_win     = decide && if_req && (starve_at_max || !ls_req);
            ls_win     = decide && !if_win;
            starve_inc = decide && if_req && !if_win;
            starve_clr = if_win || !if_req;
        end
    end

    mips_starve_ctr #(
        .MAX_STARVE (MAX_STARVE)
    ) u_starve (
        .clk    (clk),
        .rst    (rst),
        .inc    (starve_inc),
        .clr    (starve_clr),
        .at_max (starve_at_max)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= OWN_IF;
            lat_cnt    <= '0;
            drop       <= 1'b0;
            if_gnt     <= 1'b0;
            ls_gnt     <= 1'b0;
            if_valid_q <= 1'b0;
            ls_valid   <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            // Grants, strobes and valids are single-cycle pulses.
            if_gnt     <= 1'b0;
            ls_gnt     <= 1'b0;
            if_valid_q <= 1'b0;
            ls_valid   <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            case (state)
                IDLE: begin
                    drop <= 1'b0;
                    if (if_win) begin
                        if_gnt   <= 1'b1;
                        mem_en   <= 1'b1;
                        mem_addr <= if_addr;
                        owner    <= OWN_IF;
                        lat_cnt  <= LAT_W'(RD_LAT);
                        state    <= RD_WAIT;
                    end else if (ls_win) begin
                        ls_gnt    <= 1'b1;
                        mem_en    <= 1'b1;
                        mem_we    <= ls_we;
                        mem_addr  <= ls_addr;
                        mem_wdata <= ls_wdata;
                        owner     <= OWN_LS;
                        lat_cnt   <= LAT_W'(RD_LAT);
                        state     <= ls_we ? WR_DONE : RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (if_outstanding && if_flush) begin
                        drop <= 1'b1;
                    end
                    if (lat_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                        // Raise valid for the cycle in which lat_cnt reads 0,
                        // which is the cycle mem_rdata carries the word.
                        if (lat_cnt == LAT_W'(1)) begin
                            if (owner == OWN_IF) begin
                                if_valid_q <= !(drop || if_flush);
                            end else begin
                                ls_valid <= 1'b1;
                            end
                        end
                    end
                end
                WR_DONE: begin
                    // First cycle after the grant raises ls_valid; the
                    // second returns to IDLE, giving one store per 3 cycles.
                    if (ls_valid) begin
                        state <= IDLE;
                    end else begin
                        ls_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A flush arriving in the valid cycle itself still cancels the reply.
    assign if_valid = if_valid_q && !if_flush;

    // Read data passes straight through from the memory, zeroed when idle.
    assign if_rdata = if_valid ? mem_rdata : '0;
    assign ls_rdata = ls_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
module tb_mips_mem_arbiter;

    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 32;
    localparam int RD_LAT     = 2;
    localparam int MAX_STARVE = 4;
    localparam int DEPTH      = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req, if_flush, ls_req, ls_we, halt;
    logic [ADDR_W-1:0] if_addr, ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              if_gnt, if_valid, ls_gnt, ls_valid, mem_en, mem_we;
    logic [DATA_W-1:0] if_rdata, ls_rdata, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0] mem_addr;

    mips_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_STARVE(MAX_STARVE)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
        .if_rdata(if_rdata), .if_flush(if_flush),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_valid(ls_valid), .ls_rdata(ls_rdata),
        .halt(halt),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // ---------------- memory environment (fixed-latency array) ----------------
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   rd_pipe [RD_LAT];   // {read pending, address}

    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        rd_pipe[0] <= {mem_en && !mem_we, mem_addr};
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    assign mem_rdata = rd_pipe[RD_LAT-1][ADDR_W] ? mem[rd_pipe[RD_LAT-1][ADDR_W-1:0]]
                                                 : 32'h0BAD_0BAD;

    function automatic logic [DATA_W-1:0] init_word(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_flush = 1'b0; ls_req = 1'b0; ls_we = 1'b0; halt = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " strobes"}, {26'b0, if_gnt, ls_gnt, if_valid, ls_valid, mem_en, mem_we}, 32'h0);
        check({tag, " mem_addr"}, 32'(mem_addr), 32'h0);
        check({tag, " mem_wdata"}, mem_wdata, 32'h0);
        check({tag, " rdata"}, if_rdata | ls_rdata, 32'h0);
    endtask

    // ---------------- table-driven single accesses ----------------
    typedef struct {
        bit                is_if;
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        int                exp_gnt_k;    // cycles after the request edge
        int                exp_valid_k;
        logic [DATA_W-1:0] exp_data;
    } vec_t;

    task automatic run_access(input vec_t v, input int idx);
        int gk = -1;
        int vk = -1;
        int stray = 0;
        logic [DATA_W-1:0] d = '0;
        if (v.is_if) begin
            if_req = 1'b1; if_addr = v.addr;
        end else begin
            ls_req = 1'b1; ls_we = v.we; ls_addr = v.addr; ls_wdata = v.wdata;
        end
        for (int k = 1; k <= 12; k++) begin
            tick();
            if ((v.is_if ? if_gnt : ls_gnt) && gk < 0) begin
                gk = k; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
            end
            if ((v.is_if ? if_valid : ls_valid) && vk < 0) begin
                vk = k; d = v.is_if ? if_rdata : ls_rdata;
            end
            if (v.is_if ? (ls_gnt || ls_valid) : (if_gnt || if_valid)) stray++;
        end
        check($sformatf("vec%0d gnt cycle", idx), gk, v.exp_gnt_k);
        check($sformatf("vec%0d valid cycle", idx), vk, v.exp_valid_k);
        check($sformatf("vec%0d other port quiet", idx), stray, 0);
        if (!v.we) check($sformatf("vec%0d rdata", idx), d, v.exp_data);
    endtask

    // ---------------- randomized run against a timeline model ----------------
    logic [DATA_W-1:0] ref_mem [DEPTH];

    task automatic run_random(input int n);
        int free_c = 0;          // first cycle in which a new decision may happen
        int starve = 0;
        bit act = 1'b0, act_if = 1'b0, act_we = 1'b0, dropped = 1'b0;
        int g_c = -1, v_c = -1;
        logic [ADDR_W-1:0] g_addr = '0;
        logic [DATA_W-1:0] exp_d = '0;
        bit pend_if = 1'b0, pend_ls = 1'b0;
        bit e_ig, e_lg, e_iv, e_lv, win_if;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = mem[i];
        for (int c = 1; c <= n; c++) begin
            tick();
            if (!pend_if && $urandom_range(0, 2) == 0) begin
                pend_if = 1'b1; if_addr = ADDR_W'($urandom_range(0, 31));
            end else if (pend_if && $urandom_range(0, 40) == 0) begin
                pend_if = 1'b0;
            end
            if (!pend_ls && $urandom_range(0, 1) == 0) begin
                pend_ls = 1'b1; ls_addr = ADDR_W'($urandom_range(0, 31));
                ls_we = $urandom_range(0, 2) == 0; ls_wdata = $urandom;
            end else if (pend_ls && $urandom_range(0, 40) == 0) begin
                pend_ls = 1'b0;
            end
            if_req   = pend_if;
            ls_req   = pend_ls;
            halt     = $urandom_range(0, 19) == 0;
            if_flush = $urandom_range(0, 9) == 0;
            #1;
            if (act && act_if && c >= g_c && c <= v_c && if_flush) dropped = 1'b1;
            e_ig = act && act_if && c == g_c;
            e_lg = act && !act_if && c == g_c;
            e_iv = act && act_if && c == v_c && !dropped;
            e_lv = act && !act_if && c == v_c;
            check("rnd if_gnt", if_gnt, e_ig);
            check("rnd ls_gnt", ls_gnt, e_lg);
            check("rnd if_valid", if_valid, e_iv);
            check("rnd ls_valid", ls_valid, e_lv);
            check("rnd mem_en", mem_en, e_ig || e_lg);
            if (e_ig || e_lg) begin
                check("rnd mem_we", mem_we, act_we);
                check("rnd mem_addr", 32'(mem_addr), 32'(g_addr));
            end
            if (e_iv) check("rnd if_rdata", if_rdata, exp_d);
            if (e_lv && !act_we) check("rnd ls_rdata", ls_rdata, exp_d);
            // decision at the end of cycle c
            if (c >= free_c) begin
                if (!if_req) starve = 0;
                if (!halt && (if_req || ls_req)) begin
                    win_if = if_req && (starve == MAX_STARVE || !ls_req);
                    if (win_if) starve = 0;
                    else if (if_req && starve < MAX_STARVE) starve++;
                    act     = 1'b1;
                    act_if  = win_if;
                    act_we  = !win_if && ls_we;
                    g_addr  = win_if ? if_addr : ls_addr;
                    dropped = 1'b0;
                    g_c     = c + 1;
                    v_c     = act_we ? c + 2 : c + 1 + RD_LAT;
                    free_c  = act_we ? c + 3 : c + 2 + RD_LAT;
                    if (act_we) ref_mem[g_addr] = ls_wdata;
                    else exp_d = ref_mem[g_addr];
                    if (win_if) pend_if = 1'b0; else pend_ls = 1'b0;
                end
            end
        end
        idle_inputs();
        repeat (8) tick();
    endtask

    // ---------------- main sequence ----------------
    vec_t vecs [9];

    initial begin
        int g1, g2, v1, v2, ovl, cnt;
        logic [DATA_W-1:0] d1, d2;
        bit order [$];

        vecs[0] = '{1'b1, 1'b0, 10'd5,    32'h0,         1, 1 + RD_LAT, 32'h2882_0000};
        vecs[1] = '{1'b0, 1'b0, 10'd200,  32'h0,         1, 1 + RD_LAT, init_word(200)};
        vecs[2] = '{1'b0, 1'b1, 10'd300,  32'hCAFE_F00D, 1, 2,          32'h0};
        vecs[3] = '{1'b0, 1'b0, 10'd300,  32'h0,         1, 1 + RD_LAT, 32'hCAFE_F00D};
        vecs[4] = '{1'b1, 1'b0, 10'd300,  32'h0,         1, 1 + RD_LAT, 32'hCAFE_F00D};
        vecs[5] = '{1'b1, 1'b0, 10'd0,    32'h0,         1, 1 + RD_LAT, init_word(0)};
        vecs[6] = '{1'b0, 1'b0, 10'd1023, 32'h0,         1, 1 + RD_LAT, init_word(1023)};
        vecs[7] = '{1'b0, 1'b1, 10'd1023, 32'h0000_0001, 1, 2,          32'h0};
        vecs[8] = '{1'b1, 1'b0, 10'd1023, 32'h0,         1, 1 + RD_LAT, 32'h0000_0001};

        for (int i = 0; i < DEPTH; i++) mem[i] = init_word(i);
        mem[5] = 32'h2882_0000;

        rst = 1'b0; idle_inputs();
        if_addr = '0; ls_addr = '0; ls_wdata = '0;
        tick(); tick();
        check_all_zero("reset");
        rst = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) run_access(vecs[i], i);

        // Store then load held back to back: ls_valid at +2, load granted at +4.
        g1 = -1; g2 = -1; v1 = -1; v2 = -1; d1 = '0; cnt = 0;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 10'd198; ls_wdata = 32'hDEAD_BEEF;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (ls_gnt && g1 < 0) begin
                g1 = k;
                cnt = {mem_en, mem_we} == 2'b11 && mem_addr == 10'd198 && mem_wdata == 32'hDEAD_BEEF;
                ls_we = 1'b0;
            end else if (ls_gnt && g2 < 0) begin
                g2 = k; ls_req = 1'b0;
            end
            if (ls_valid && v1 < 0) v1 = k;
            else if (ls_valid && v2 < 0) begin v2 = k; d1 = ls_rdata; end
        end
        check("st/ld store command on bus", cnt, 1);
        check("st/ld store gnt", g1, 1);
        check("st/ld store valid", v1, 2);
        check("st/ld load gnt", g2, 4);
        check("st/ld load valid", v2, 4 + RD_LAT);
        check("st/ld load data", d1, 32'hDEAD_BEEF);

        // Back-to-back fetches held continuously: one read per RD_LAT+2 cycles.
        g1 = -1; g2 = -1; v1 = -1; v2 = -1;
        if_req = 1'b1; if_addr = 10'd7;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (if_gnt && g1 < 0) begin g1 = k; if_addr = 10'd8; end
            else if (if_gnt && g2 < 0) begin g2 = k; if_req = 1'b0; end
            if (if_valid && v1 < 0) begin v1 = k; d1 = if_rdata; end
            else if (if_valid && v2 < 0) begin v2 = k; d2 = if_rdata; end
        end
        check("b2b fetch gnt1", g1, 1);
        check("b2b fetch gnt2", g2, 3 + RD_LAT);
        check("b2b fetch data1", d1, init_word(7));
        check("b2b fetch data2", d2, init_word(8));

        // Simultaneous requests: LS first, IF at the next IDLE decision.
        g1 = -1; g2 = -1; v1 = -1; v2 = -1; ovl = 0;
        if_req = 1'b1; if_addr = 10'd5; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 10'd200;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (if_gnt && ls_gnt) ovl++;
            if (ls_gnt && g1 < 0) begin g1 = k; ls_req = 1'b0; end
            if (if_gnt && g2 < 0) begin g2 = k; if_req = 1'b0; end
            if (ls_valid && v1 < 0) begin v1 = k; d1 = ls_rdata; end
            if (if_valid && v2 < 0) begin v2 = k; d2 = if_rdata; end
        end
        check("simul ls gnt", g1, 1);
        check("simul ls valid", v1, 1 + RD_LAT);
        check("simul ls data", d1, init_word(200));
        check("simul if gnt", g2, 3 + RD_LAT);
        check("simul if data", d2, 32'h2882_0000);
        check("simul no overlap", ovl, 0);

        // Starvation: both held -> 4 LS grants, 1 IF grant, then LS again.
        ovl = 0; order.delete();
        if_req = 1'b1; if_addr = 10'd20; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 10'd10;
        for (int k = 1; k <= 60 && order.size() < 6; k++) begin
            tick();
            if ((if_gnt && ls_gnt) || (if_valid && ls_valid)) ovl++;
            if (ls_gnt) begin order.push_back(1'b1); ls_addr = ls_addr + 1'b1; end
            if (if_gnt) order.push_back(1'b0);
        end
        idle_inputs();
        check("starve grant count", order.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < order.size())
                check($sformatf("starve grant %0d is LS", i), order[i], (i == MAX_STARVE) ? 0 : 1);
        check("starve no overlap", ovl, 0);
        repeat (8) tick();

        // Flush one cycle after if_gnt: no if_valid for that fetch.
        g1 = -1; cnt = 0;
        if_req = 1'b1; if_addr = 10'd5;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (if_gnt && g1 < 0) begin g1 = k; if_req = 1'b0; end
            if_flush = (k == 2);
            #1;
            if (if_valid) cnt++;
        end
        if_flush = 1'b0;
        check("flush gnt", g1, 1);
        check("flush suppresses valid", cnt, 0);
        // Flush landing in the valid cycle itself also suppresses it.
        cnt = 0;
        if_req = 1'b1; if_addr = 10'd9;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (if_gnt) if_req = 1'b0;
            if_flush = (k == 1 + RD_LAT);
            #1;
            if (if_valid) cnt++;
        end
        if_flush = 1'b0;
        check("flush in valid cycle", cnt, 0);
        run_access(vecs[0], 100);
        // Flush has no effect on a load.
        v1 = -1; d1 = '0;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 10'd200; if_flush = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (ls_gnt) ls_req = 1'b0;
            if (ls_valid && v1 < 0) begin v1 = k; d1 = ls_rdata; end
        end
        if_flush = 1'b0;
        check("flush ignored by ls valid", v1, 1 + RD_LAT);
        check("flush ignored by ls data", d1, init_word(200));

        // Halt blocks new grants but lets an outstanding fetch finish.
        g1 = -1; v1 = -1; cnt = 0;
        halt = 1'b1; if_req = 1'b1; if_addr = 10'd11;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k <= 6 && (if_gnt || ls_gnt)) cnt++;
            if (k == 6) halt = 1'b0;
            if (if_gnt && g1 < 0) begin g1 = k; if_req = 1'b0; end
            if (k == 8) halt = 1'b1;
            if (if_valid && v1 < 0) begin v1 = k; d1 = if_rdata; end
        end
        halt = 1'b0;
        check("halt blocks grant", cnt, 0);
        check("halt release gnt", g1, 7);
        check("halt keeps outstanding valid", v1, 7 + RD_LAT);
        check("halt outstanding data", d1, init_word(11));

        // Reset in the middle of RD_WAIT abandons the access.
        if_req = 1'b1; if_addr = 10'd12;
        tick(); if_req = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check_all_zero("async reset");
        tick();
        check_all_zero("reset next cycle");
        rst = 1'b1;
        cnt = 0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (if_valid || ls_valid || if_gnt || ls_gnt) cnt++;
        end
        check("abandoned access silent", cnt, 0);
        run_access(vecs[5], 200);

        run_random(1500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

endmodule
